// File: rtl/dmem_mmio_responder.sv
// Data-port responder: internal word RAM plus an MMIO file holding a
// 64-bit machine timer, a scratch register and a byte-wide TX FIFO.
module dmem_mmio_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h0001_0000,
  parameter int unsigned TX_DEPTH  = 4,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addrb,
  input  logic [3:0]  web,
  input  logic [31:0] dib,
  input  logic        re,
  output logic [31:0] dob,
  output logic        bus_err,
  output logic        timer_irq,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TX_DEPTH);
  localparam logic [31:0] RAM_TOP  = 32'(DEPTH * 4);
  localparam logic [31:0] MMIO_TOP = MMIO_BASE + 32'h1C;

  function automatic logic [31:0] f_merge(
    input logic [31:0] o,
    input logic [31:0] d,
    input logic [3:0]  be
  );
    logic [31:0] m;
    m = o;
    for (int i = 0; i < 4; i++)
      if (be[i]) m[8*i +: 8] = d[8*i +: 8];
    return m;
  endfunction

  logic [31:0]   r_ram [DEPTH];
  logic [63:0]   r_mtime;
  logic [63:0]   r_mtcmp;
  logic [31:0]   r_pre;
  logic [31:0]   r_scratch;
  logic [7:0]    r_txq [TX_DEPTH];
  logic [TW-1:0] r_wp;
  logic [TW-1:0] r_rp;
  logic [TW:0]   r_cnt;
  logic          r_ovf;
  logic [31:0]   r_dob;
  logic          r_bus_err;
  logic          r_irq;

  logic          w_ram;
  logic          w_mmio;
  logic          w_wr;
  logic [AW-1:0] w_idx;
  logic [6:0]    w_sel;
  logic          w_tick;
  logic [63:0]   w_mtime_nxt;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push;
  logic          w_clr;
  logic [31:0]   w_status;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_unused = ^addrb[1:0];
  assign w_ram    = addrb < RAM_TOP;
  assign w_mmio   = (addrb >= MMIO_BASE) && (addrb < MMIO_TOP);
  assign w_wr     = |web;
  assign w_idx    = addrb[AW+1:2];
  // one-hot MMIO write strobe per register offset
  assign w_sel    = (w_mmio && w_wr) ? 7'(8'd1 << addrb[4:2]) : 7'd0;

  assign w_tick = (r_pre == PRESCALE - 1);

  always_comb begin
    w_mtime_nxt = r_mtime + {63'd0, w_tick};
    if (w_sel[0])
      w_mtime_nxt = {r_mtime[63:32], f_merge(r_mtime[31:0], dib, web)};
    if (w_sel[1])
      w_mtime_nxt = {f_merge(r_mtime[63:32], dib, web), r_mtime[31:0]};
  end

  assign w_full     = (r_cnt == (TW+1)'(TX_DEPTH));
  assign w_empty    = (r_cnt == '0);
  assign w_pop      = !w_empty && tx_ready;
  assign w_push_req = w_sel[4] && web[0];
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_clr      = w_sel[5] && web[0] && dib[5];
  assign w_status   = {26'd0, r_ovf, 3'(r_cnt), w_empty, w_full};

  always_comb begin
    w_rdata = '0;
    if (w_ram) begin
      w_rdata = r_ram[w_idx];
    end else if (w_mmio) begin
      unique case (addrb[4:2])
        3'd0:    w_rdata = r_mtime[31:0];
        3'd1:    w_rdata = r_mtime[63:32];
        3'd2:    w_rdata = r_mtcmp[31:0];
        3'd3:    w_rdata = r_mtcmp[63:32];
        3'd5:    w_rdata = w_status;
        3'd6:    w_rdata = r_scratch;
        default: w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_ram) begin
      for (int i = 0; i < 4; i++)
        if (web[i]) r_ram[w_idx][8*i +: 8] <= dib[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dob     <= '0;
      r_bus_err <= 1'b0;
      r_irq     <= 1'b0;
      r_pre     <= '0;
      r_mtime   <= '0;
      r_mtcmp   <= '1;
      r_scratch <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      for (int i = 0; i < TX_DEPTH; i++) r_txq[i] <= '0;
    end else begin
      r_dob     <= w_rdata;
      r_bus_err <= !w_ram && !w_mmio && (re || w_wr);
      r_irq     <= r_mtime >= r_mtcmp;
      r_pre     <= w_tick ? '0 : r_pre + 32'd1;
      r_mtime   <= w_mtime_nxt;
      if (w_sel[2]) r_mtcmp[31:0]  <= f_merge(r_mtcmp[31:0], dib, web);
      if (w_sel[3]) r_mtcmp[63:32] <= f_merge(r_mtcmp[63:32], dib, web);
      if (w_sel[6]) r_scratch <= f_merge(r_scratch, dib, web);
      if (w_push) begin
        r_txq[r_wp] <= dib[7:0];
        r_wp        <= r_wp + TW'(1);
      end
      if (w_pop) r_rp <= r_rp + TW'(1);
      if (w_push && !w_pop)
        r_cnt <= r_cnt + (TW+1)'(1);
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - (TW+1)'(1);
      // a dropped push in the same cycle beats a clear
      if (w_push_req && !w_push)
        r_ovf <= 1'b1;
      else if (w_clr)
        r_ovf <= 1'b0;
    end
  end

  assign dob       = r_dob;
  assign bus_err   = r_bus_err;
  assign timer_irq = r_irq;
  assign tx_valid  = !w_empty;
  assign tx_data   = r_txq[r_rp];

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Scoreboard bench: stimulus queues expected outputs per cycle,
// a monitor pops and compares them after each rising edge.
module tb_dmem_mmio_responder;

  localparam logic [31:0] MB   = 32'h0001_0000;
  localparam logic [31:0] MTLO = MB + 32'h00;
  localparam logic [31:0] MTHI = MB + 32'h04;
  localparam logic [31:0] CLO  = MB + 32'h08;
  localparam logic [31:0] CHI  = MB + 32'h0C;
  localparam logic [31:0] TXD  = MB + 32'h10;
  localparam logic [31:0] TXS  = MB + 32'h14;
  localparam logic [31:0] SCR  = MB + 32'h18;

  logic        clk = 0;
  logic        rst = 1;
  logic [31:0] addrb = '0;
  logic [3:0]  web = '0;
  logic [31:0] dib = '0;
  logic        re = 0;
  logic [31:0] dob;
  logic        bus_err;
  logic        timer_irq;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    bit          cd;
    logic [31:0] d;
    bit          ce;
    logic        e;
    bit          ci;
    logic        i;
    bit          cv;
    logic        v;
    bit          ct;
    logic [7:0]  t;
  } exp_t;

  exp_t q[$];
  exp_t nx;

  dmem_mmio_responder dut (
    .clk(clk), .rst(rst), .addrb(addrb), .web(web), .dib(dib),
    .re(re), .dob(dob), .bus_err(bus_err), .timer_irq(timer_irq),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic clr();
    nx.cd = 0; nx.ce = 0; nx.ci = 0; nx.cv = 0; nx.ct = 0;
    nx.d = '0; nx.e = 0; nx.i = 0; nx.v = 0; nx.t = '0;
  endtask

  task automatic xd(input logic [31:0] v); nx.cd = 1; nx.d = v; endtask
  task automatic xe(input logic v); nx.ce = 1; nx.e = v; endtask
  task automatic xi(input logic v); nx.ci = 1; nx.i = v; endtask
  task automatic xv(input logic v); nx.cv = 1; nx.v = v; endtask
  task automatic xt(input logic [7:0] v); nx.ct = 1; nx.t = v; endtask

  task automatic go(input string nm, input logic r, input logic [31:0] a,
                    input logic [3:0] w, input logic [31:0] d,
                    input logic rd, input logic rdy);
    @(negedge clk);
    rst = r; addrb = a; web = w; dib = d; re = rd; tx_ready = rdy;
    nx.nm = nm;
    q.push_back(nx);
    clr();
  endtask

  task automatic chk(input string nm, input string f,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, f, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.cd) chk(e.nm, "dob", dob, e.d);
        if (e.ce) chk(e.nm, "bus_err", 32'(bus_err), 32'(e.e));
        if (e.ci) chk(e.nm, "timer_irq", 32'(timer_irq), 32'(e.i));
        if (e.cv) chk(e.nm, "tx_valid", 32'(tx_valid), 32'(e.v));
        if (e.ct) chk(e.nm, "tx_data", 32'(tx_data), 32'(e.t));
      end
    end
  end

  initial begin : stim
    clr();
    // reset state
    xd(0); xe(0); xi(0); xv(0); xt(0);
    go("rst0", 1, 0, 0, 0, 0, 0);
    go("rst1", 1, 0, 0, 0, 0, 0);

    // RAM byte enables and read-during-write
    go("w0", 0, 32'h0, 4'hF, 32'h0BAD_F00D, 0, 0);
    go("w40", 0, 32'h40, 4'hF, 32'hDEAD_BEEF, 0, 0);
    xd(32'hDEAD_BEEF);
    go("w40b", 0, 32'h40, 4'b0010, 32'h0000_5500, 0, 0);
    xd(32'hDEAD_55EF);
    go("r40", 0, 32'h40, 0, 0, 1, 0);
    go("w80", 0, 32'h80, 4'hF, 32'h1111_1111, 0, 0);
    xd(32'h1111_1111);
    go("rdw80", 0, 32'h80, 4'hF, 32'h2222_2222, 1, 0);
    xd(32'h2222_2222);
    go("r80", 0, 32'h80, 0, 0, 1, 0);

    // scratch with byte enables
    xd(0);
    go("scr", 0, SCR, 4'hF, 32'hA5A5_A5A5, 0, 0);
    xd(32'hA5A5_A5A5);
    go("scrb", 0, SCR, 4'b0100, 32'h0077_0000, 0, 0);
    xd(32'hA577_A5A5);
    go("rscr", 0, SCR, 0, 0, 1, 0);

    // decode boundaries and unmapped accesses
    xd(0); xe(1);
    go("unm", 0, 32'h0002_0000, 0, 0, 1, 0);
    xd(32'hDEAD_55EF); xe(0);
    go("idle", 0, 32'h40, 0, 0, 0, 0);
    xd(0); xe(1);
    go("unmw", 0, 32'h0002_0000, 4'hF, 32'hFFFF_FFFF, 0, 0);
    xd(32'h0BAD_F00D); xe(0);
    go("r0", 0, 32'h0, 0, 0, 1, 0);
    xd(0); xe(1);
    go("ramtop", 0, 32'h1000, 0, 0, 1, 0);
    xe(0);
    go("ramend", 0, 32'hFFC, 0, 0, 1, 0);
    xd(0); xe(1);
    go("mmtop", 0, MB + 32'h1C, 0, 0, 1, 0);
    xe(0);
    go("unmidle", 0, 32'h0002_0000, 0, 0, 0, 0);

    // timer compare
    xd(32'hFFFF_FFFF); xi(0);
    go("cmplo", 0, CLO, 4'hF, 32'd10, 0, 0);
    xi(0);
    go("mtlo0", 0, MTLO, 4'hF, 32'd0, 0, 0);
    xd(32'hFFFF_FFFF); xi(0);
    go("cmphi", 0, CHI, 4'hF, 32'd0, 0, 0);
    for (int k = 2; k <= 12; k++) begin
      xd(32'(k - 1)); xi(k >= 11);
      go("mt", 0, MTLO, 0, 0, 1, 0);
    end

    // low-half carry into high half
    xd(32'd12);
    go("mtwrap", 0, MTLO, 4'hF, 32'hFFFF_FFFF, 0, 0);
    xd(0);
    go("hi0", 0, MTHI, 0, 0, 1, 0);
    xd(0);
    go("lo0", 0, MTLO, 0, 0, 1, 0);
    xd(1);
    go("hi1", 0, MTHI, 0, 0, 1, 0);

    // FIFO fill and overflow
    for (int k = 0; k < 5; k++) begin
      xd(0); xv(1); xt(8'h41);
      go("push", 0, TXD, 4'b0001, 32'(8'h41 + k), 0, 0);
    end
    xd(32'h31); xv(1); xt(8'h41);
    go("stfull", 0, TXS, 0, 0, 1, 0);
    xd(32'h31); xt(8'h42);
    go("pop1", 0, TXS, 0, 0, 1, 1);
    xd(32'h2C); xt(8'h43);
    go("pop2", 0, TXS, 0, 0, 1, 1);
    xd(32'h28); xt(8'h44);
    go("pop3", 0, TXS, 0, 0, 1, 1);
    xd(32'h24); xv(0);
    go("pop4", 0, TXS, 0, 0, 1, 1);
    xd(32'h22);
    go("w1c", 0, TXS, 4'b0001, 32'h20, 0, 0);
    xd(32'h02);
    go("stclr", 0, TXS, 0, 0, 1, 0);

    // full FIFO with simultaneous push and pop
    for (int k = 0; k < 4; k++) begin
      xv(1); xt(8'h50);
      go("fill", 0, TXD, 4'b0001, 32'(8'h50 + k), 0, 0);
    end
    xv(1); xt(8'h51);
    go("pushpop", 0, TXD, 4'b0001, 32'h5A, 0, 1);
    xd(32'h11); xt(8'h51);
    go("stpp", 0, TXS, 0, 0, 1, 0);
    xd(32'h11); xt(8'h52);
    go("dr1", 0, TXS, 0, 0, 1, 1);
    xd(32'h0C); xt(8'h53);
    go("dr2", 0, TXS, 0, 0, 1, 1);
    xd(32'h08); xt(8'h5A);
    go("dr3", 0, TXS, 0, 0, 1, 1);
    xd(32'h04); xv(0);
    go("dr4", 0, TXS, 0, 0, 1, 1);
    xd(32'h02); xv(0);
    go("drend", 0, TXS, 0, 0, 1, 0);

    // mid-operation reset
    xv(1); xt(8'h61);
    go("p61", 0, TXD, 4'b0001, 32'h61, 0, 0);
    xv(1); xt(8'h61); xi(1);
    go("p62", 0, TXD, 4'b0001, 32'h62, 0, 0);
    xd(0); xe(0); xi(0); xv(0); xt(0);
    go("rstmid", 1, SCR, 4'hF, 32'h1234_5678, 1, 0);
    xd(0); xi(0);
    go("rmt", 0, MTLO, 0, 0, 1, 0);
    xd(0);
    go("rscr0", 0, SCR, 0, 0, 1, 0);
    xd(32'hFFFF_FFFF);
    go("rcmp", 0, CLO, 0, 0, 1, 0);
    xd(32'h02); xv(0);
    go("rst_st", 0, TXS, 0, 0, 1, 0);
    go("end", 0, 32'h40, 0, 0, 0, 0);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    #5;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
